circular_packer: RTL and testbench
==================================

CIRCULAR_PACKER -- requirements
Module: circular_packer

Interface
REQ-001 SHALL have parameter ELEM_WIDTH, default 8, width of each element.
REQ-002 SHALL have parameter NUM_ELEM, default 4, elements per beat and per output word; >= 2.
REQ-003 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port arst_ni  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port data_i  input  ELEM_WIDTH x NUM_ELEM unpacked array  input elements; lanes 0..cnt_i-1 are meaningful.
REQ-006 SHALL have port cnt_i  input  $clog2(NUM_ELEM+1)  number of valid input lanes, 0..NUM_ELEM.
REQ-007 SHALL have port last_i  input  1  beat ends a packet; flush all held elements.
REQ-008 SHALL have port valid_i  input  1  input beat valid.
REQ-009 SHALL have port ready_o  output  1  input beat accepted when valid_i && ready_o.
REQ-010 SHALL have port data_o  output  ELEM_WIDTH x NUM_ELEM unpacked array  packed output word.
REQ-011 SHALL have port cnt_o  output  $clog2(NUM_ELEM+1)  valid lanes in data_o, 1..NUM_ELEM.
REQ-012 SHALL have port valid_o  output  1  output word valid.
REQ-013 SHALL have port ready_i  input  1  output word consumed when valid_o && ready_i.

Function
REQ-014 SHALL keep staging register stage[NUM_ELEM] and fill count, 0..NUM_ELEM-1; lanes >= fill SHALL be zero.
REQ-015 SHALL rotate each accepted beat so input lane j lands at lane (fill+j) mod NUM_ELEM, combinationally.
REQ-016 SHALL clamp cnt_i > NUM_ELEM to NUM_ELEM.
REQ-017 On accept, with total = fill + cnt_i: if total < NUM_ELEM and !last_i, SHALL write rotated lanes fill..total-1 into stage and set fill = total; no word emitted.
REQ-018 If total >= NUM_ELEM, SHALL emit a word with stage lanes 0..fill-1 plus rotated lanes fill..NUM_ELEM-1 and cnt_o = NUM_ELEM. Leftover rotated lanes 0..total-NUM_ELEM-1 SHALL go to stage, with fill = total - NUM_ELEM.
REQ-019 If last_i and 0 < total <= NUM_ELEM, SHALL emit the combined word with cnt_o = total, zeros above, and set fill = 0.
REQ-020 If last_i and total > NUM_ELEM, SHALL emit a full word per REQ-018 and enter state DRAIN. In DRAIN, SHALL emit the leftover word (cnt_o = fill) when the output slot is free, then set fill = 0 and return to ACCUM.
REQ-021 If last_i and total == 0, SHALL emit nothing.
REQ-022 States SHALL be ACCUM and DRAIN only; DRAIN SHALL last exactly until the leftover word is loaded.
REQ-023 ready_o SHALL equal (state == ACCUM) && (!valid_o || ready_i), combinationally from registers and ready_i.
REQ-024 Output word SHALL be registered, with valid_o asserted the cycle after the accepting edge (latency 1).
REQ-025 While valid_o && !ready_i, data_o, cnt_o and valid_o SHALL hold stable.
REQ-026 On valid_o && ready_i with no new word, SHALL clear valid_o. With a new word the same edge, SHALL load it back-to-back with valid_o staying 1.
REQ-027 valid_i && cnt_i == 0 && !last_i SHALL be accepted with no state change.

Reset
REQ-028 On arst_ni low, immediately and regardless of clock, SHALL force:
- valid_o = 0, cnt_o = 0, data_o all zero;
- stage all zero, fill = 0, state = ACCUM.
REQ-029 Reset mid-packet SHALL discard held elements; after release ready_o = 1 and no word SHALL be emitted before new input.

Verification (NUM_ELEM=4, ELEM_WIDTH=8, ready_i=1 unless stated)
REQ-030 Beats {A0,A1,A2}, {B0,B1,B2}, {C0,C1,C2}, each cnt_i=3, back-to-back -> output is:
- {A0,A1,A2,B0} cnt_o=4, one cycle after the B accept;
- {B1,B2,C0,C1} cnt_o=4, one cycle after the C accept;
- fill=1 holding C2.
REQ-031 Beat cnt_i=3 {A0..A2}, then cnt_i=3 {B0..B2} with last_i -> output is:
- {A0,A1,A2,B0} cnt_o=4;
- next cycle {B1,B2,0,0} cnt_o=2;
- ready_o=0 during the DRAIN cycle, then 1.
REQ-032 valid_o=1 with ready_i=0 for 5 cycles -> data_o/cnt_o stable, ready_o=0, no beat accepted. ready_i=1 -> next word follows with no bubble.
REQ-033 last_i, cnt_i=0, fill=0 -> no word. last_i, cnt_i=0, fill=2 -> one word with cnt_o=2, lanes 2..3 zero.
REQ-034 cnt_i=4 every cycle, fill=0 -> each beat passes unchanged, cnt_o=4, one word per cycle.
REQ-035 arst_ni low while fill=3 and valid_o=1 -> valid_o=0, cnt_o=0 immediately. Next beat cnt_i=4 {D0..D3} -> word {D0,D1,D2,D3}.

Source files
------------

// File: rtl/circular_packer.sv
// rtl/circular_packer.sv - packs variable-count element beats into full output words
// Ports:
//   clk_i, arst_ni   clock; asynchronous active-low reset
//   data_i, cnt_i    input elements, lanes 0..cnt_i-1 meaningful (cnt_i clamped to NUM_ELEM)
//   last_i           beat closes a packet; every held element is flushed
//   valid_i, ready_o input beat handshake
//   data_o, cnt_o    registered output word and its valid lane count
//   valid_o, ready_i output word handshake
module circular_packer #(
  parameter int ELEM_WIDTH = 8,
  parameter int NUM_ELEM   = 4,
  localparam int CW        = $clog2(NUM_ELEM + 1)
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic [ELEM_WIDTH-1:0] data_i [NUM_ELEM],
  input  logic [CW-1:0]         cnt_i,
  input  logic                  last_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [ELEM_WIDTH-1:0] data_o [NUM_ELEM],
  output logic [CW-1:0]         cnt_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  localparam int IW = $clog2(NUM_ELEM);

  typedef enum logic {ACCUM = 1'b0, DRAIN = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         fill_q, fill_d;
  logic [ELEM_WIDTH-1:0] stage_q [NUM_ELEM];
  logic [ELEM_WIDTH-1:0] stage_d [NUM_ELEM];
  logic [ELEM_WIDTH-1:0] out_data_q [NUM_ELEM];
  logic [ELEM_WIDTH-1:0] out_data_d [NUM_ELEM];
  logic [CW-1:0]         out_cnt_q, out_cnt_d;
  logic                  out_valid_q, out_valid_d;

  logic [ELEM_WIDTH-1:0] rot [NUM_ELEM];
  logic                  slot_free;
  logic                  accept;
  int                    fill_n, cnt_n, total_n;

  // State register
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      fill_q      <= '0;
      stage_q     <= '{default: '0};
      out_data_q  <= '{default: '0};
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fill_q      <= fill_d;
      stage_q     <= stage_d;
      out_data_q  <= out_data_d;
      out_cnt_q   <= out_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Handshake outputs: the output slot is free when empty or being consumed now
  always_comb begin
    slot_free = !out_valid_q || ready_i;
    ready_o   = (state_q == ACCUM) && slot_free;
    accept    = valid_i && ready_o;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM: if (accept && last_i && (total_n > NUM_ELEM)) state_d = DRAIN;
      DRAIN: if (slot_free) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // Rotate the beat so input lane j lines up with staging lane fill+j
  always_comb begin
    fill_n  = int'(fill_q);
    cnt_n   = (int'(cnt_i) > NUM_ELEM) ? NUM_ELEM : int'(cnt_i);
    total_n = fill_n + cnt_n;
    for (int k = 0; k < NUM_ELEM; k++) begin
      rot[k] = data_i[IW'((k + NUM_ELEM - fill_n) % NUM_ELEM)];
    end
  end

  // Staging and output word updates
  always_comb begin
    fill_d      = fill_q;
    stage_d     = stage_q;
    out_data_d  = out_data_q;
    out_cnt_d   = out_cnt_q;
    out_valid_d = out_valid_q && !ready_i;

    if (state_q == DRAIN) begin
      if (slot_free) begin
        out_data_d  = stage_q;
        out_cnt_d   = fill_q;
        out_valid_d = 1'b1;
        stage_d     = '{default: '0};
        fill_d      = '0;
      end
    end else if (accept) begin
      if (total_n >= NUM_ELEM) begin
        // Full word: held lanes below fill, rotated lanes above; wrapped lanes stay behind
        for (int k = 0; k < NUM_ELEM; k++) begin
          out_data_d[k] = (k < fill_n) ? stage_q[k] : rot[k];
          stage_d[k]    = (k < total_n - NUM_ELEM) ? rot[k] : '0;
        end
        out_cnt_d   = CW'(NUM_ELEM);
        out_valid_d = 1'b1;
        fill_d      = CW'(total_n - NUM_ELEM);
      end else if (last_i) begin
        if (total_n > 0) begin
          for (int k = 0; k < NUM_ELEM; k++) begin
            out_data_d[k] = (k < fill_n) ? stage_q[k] : ((k < total_n) ? rot[k] : '0);
          end
          out_cnt_d   = CW'(total_n);
          out_valid_d = 1'b1;
        end
        stage_d = '{default: '0};
        fill_d  = '0;
      end else begin
        for (int k = 0; k < NUM_ELEM; k++) begin
          if ((k >= fill_n) && (k < total_n)) stage_d[k] = rot[k];
        end
        fill_d = CW'(total_n);
      end
    end
  end

  assign data_o  = out_data_q;
  assign cnt_o   = out_cnt_q;
  assign valid_o = out_valid_q;

endmodule

// File: tb/tb_circular_packer.sv
// tb/tb_circular_packer.sv - self-checking bench for circular_packer
module tb_circular_packer;

  localparam int EW = 8;
  localparam int NE = 4;
  localparam int CW = $clog2(NE + 1);
  localparam int W  = NE * EW;
  localparam logic [CW-1:0] FULL = CW'(NE);

  typedef struct {
    logic [W-1:0] d;
    int           cnt;
  } word_t;

  logic          clk_i   = 1'b0;
  logic          arst_ni = 1'b1;
  logic [EW-1:0] data_i [NE];
  logic [CW-1:0] cnt_i   = '0;
  logic          last_i  = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [EW-1:0] data_o [NE];
  logic [CW-1:0] cnt_o;
  logic          valid_o;
  logic          ready_i = 1'b1;

  logic [W-1:0]  in_vec = '0;
  logic [W-1:0]  out_vec;

  int checks   = 0;
  int errors   = 0;
  int accepts  = 0;
  bit rand_ready = 1'b0;

  // Reference model: a flat element stream cut into words of NE, flushed on last
  logic [EW-1:0] held [$];
  word_t         exp_q [$];
  word_t         obs_q [$];
  word_t         mon_w, mon_e;
  int            mon_n;

  for (genvar g = 0; g < NE; g++) begin : g_lane
    assign data_i[g]             = in_vec[g*EW +: EW];
    assign out_vec[g*EW +: EW]   = data_o[g];
  end

  circular_packer #(.ELEM_WIDTH(EW), .NUM_ELEM(NE)) dut (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .data_i  (data_i),
    .cnt_i   (cnt_i),
    .last_i  (last_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .cnt_o   (cnt_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (arst_ni) begin
      if (valid_o && ready_i) begin
        mon_w.d   = out_vec;
        mon_w.cnt = int'(cnt_o);
        obs_q.push_back(mon_w);
      end
      if (valid_i && ready_o) begin
        accepts++;
        mon_n = (int'(cnt_i) > NE) ? NE : int'(cnt_i);
        for (int j = 0; j < mon_n; j++) held.push_back(in_vec[j*EW +: EW]);
        while (held.size() >= NE) begin
          mon_e.d   = '0;
          mon_e.cnt = NE;
          for (int k = 0; k < NE; k++) mon_e.d[k*EW +: EW] = held.pop_front();
          exp_q.push_back(mon_e);
        end
        if (last_i && (held.size() > 0)) begin
          mon_e.d   = '0;
          mon_e.cnt = held.size();
          for (int k = 0; k < mon_e.cnt; k++) mon_e.d[k*EW +: EW] = held.pop_front();
          exp_q.push_back(mon_e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (rand_ready) ready_i = ($urandom_range(0, 9) < 7);
  endtask

  task automatic send_beat(input logic [W-1:0] d, input int cnt, input bit last);
    bit ok;
    int guard;
    in_vec  = d;
    cnt_i   = CW'(cnt);
    last_i  = last;
    valid_i = 1'b1;
    ok      = 1'b0;
    guard   = 0;
    while (!ok && guard < 200) begin
      @(negedge clk_i);
      ok = ready_o;
      tick();
      guard++;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: ready_o stayed 0 for %0d cycles, required 1", guard);
    end
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic do_reset();
    valid_i    = 1'b0;
    last_i     = 1'b0;
    cnt_i      = '0;
    rand_ready = 1'b0;
    ready_i    = 1'b1;
    #2 arst_ni = 1'b0;
    #3 arst_ni = 1'b1;
    held.delete();
    exp_q.delete();
    obs_q.delete();
    tick();
  endtask

  task automatic test_reset();
    #2 arst_ni = 1'b0;
    #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", valid_o); end
    checks++; if (cnt_o !== '0) begin errors++; $display("FAIL reset_cnt: got %0d required 0", cnt_o); end
    checks++; if (out_vec !== '0) begin errors++; $display("FAIL reset_data: got %h required 0", out_vec); end
    @(posedge clk_i);
    #1 arst_ni = 1'b1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", ready_o); end
    tick(); tick();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_no_word: got %b required 0", valid_o); end
  endtask

  task automatic test_rotate();
    logic [W-1:0] a, b, c, e;
    do_reset();
    a = $urandom(); b = $urandom(); c = $urandom();
    send_beat(a, 3, 1'b0);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rot_no_word: valid %b required 0", valid_o); end
    send_beat(b, 3, 1'b0);
    e = {b[EW-1:0], a[3*EW-1:0]};
    checks++;
    if (valid_o !== 1'b1 || out_vec !== e || cnt_o !== FULL) begin
      errors++; $display("FAIL rot_word1: valid %b data %h cnt %0d required 1 %h 4", valid_o, out_vec, cnt_o, e);
    end
    send_beat(c, 3, 1'b0);
    e = {c[2*EW-1:0], b[3*EW-1:EW]};
    checks++;
    if (valid_o !== 1'b1 || out_vec !== e || cnt_o !== FULL) begin
      errors++; $display("FAIL rot_word2: valid %b data %h cnt %0d required 1 %h 4", valid_o, out_vec, cnt_o, e);
    end
    send_beat($urandom(), 0, 1'b1);
    e = {{(3*EW){1'b0}}, c[3*EW-1:2*EW]};
    checks++;
    if (valid_o !== 1'b1 || out_vec !== e || cnt_o !== CW'(1)) begin
      errors++; $display("FAIL rot_held_c2: valid %b data %h cnt %0d required 1 %h 1", valid_o, out_vec, cnt_o, e);
    end
  endtask

  task automatic test_last_drain();
    logic [W-1:0] a, b, e;
    do_reset();
    a = $urandom(); b = $urandom();
    send_beat(a, 3, 1'b0);
    send_beat(b, 3, 1'b1);
    e = {b[EW-1:0], a[3*EW-1:0]};
    checks++;
    if (valid_o !== 1'b1 || out_vec !== e || cnt_o !== FULL) begin
      errors++; $display("FAIL drain_word1: valid %b data %h cnt %0d required 1 %h 4", valid_o, out_vec, cnt_o, e);
    end
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL drain_ready_low: got %b required 0", ready_o); end
    tick();
    e = {{(2*EW){1'b0}}, b[3*EW-1:EW]};
    checks++;
    if (valid_o !== 1'b1 || out_vec !== e || cnt_o !== CW'(2)) begin
      errors++; $display("FAIL drain_word2: valid %b data %h cnt %0d required 1 %h 2", valid_o, out_vec, cnt_o, e);
    end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL drain_ready_back: got %b required 1", ready_o); end
    tick();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL drain_idle: valid %b required 0", valid_o); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b;
    int n0;
    do_reset();
    a = $urandom(); b = $urandom();
    ready_i = 1'b0;
    send_beat(a, 4, 1'b0);
    in_vec = b; cnt_i = FULL; valid_i = 1'b1;
    n0 = accepts;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (valid_o !== 1'b1 || out_vec !== a || cnt_o !== FULL || ready_o !== 1'b0) begin
        errors++; $display("FAIL stall_hold[%0d]: valid %b data %h cnt %0d ready %b required 1 %h 4 0", i, valid_o, out_vec, cnt_o, ready_o, a);
      end
      tick();
    end
    checks++; if (accepts !== n0) begin errors++; $display("FAIL stall_no_accept: accepts %0d required %0d", accepts, n0); end
    ready_i = 1'b1;
    tick();
    valid_i = 1'b0;
    checks++;
    if (valid_o !== 1'b1 || out_vec !== b || cnt_o !== FULL) begin
      errors++; $display("FAIL stall_release: valid %b data %h cnt %0d required 1 %h 4", valid_o, out_vec, cnt_o, b);
    end
    tick();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL stall_idle: valid %b required 0", valid_o); end
  endtask

  task automatic test_empty_last();
    logic [W-1:0] a, e;
    do_reset();
    a = $urandom();
    send_beat($urandom(), 0, 1'b1);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL empty_last_word: valid %b required 0", valid_o); end
    tick();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL empty_last_later: valid %b required 0", valid_o); end
    send_beat(a, 2, 1'b0);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL empty_partial: valid %b required 0", valid_o); end
    send_beat($urandom(), 0, 1'b1);
    e = {{(2*EW){1'b0}}, a[2*EW-1:0]};
    checks++;
    if (valid_o !== 1'b1 || out_vec !== e || cnt_o !== CW'(2)) begin
      errors++; $display("FAIL empty_flush: valid %b data %h cnt %0d required 1 %h 2", valid_o, out_vec, cnt_o, e);
    end
  endtask

  task automatic test_passthrough();
    logic [W-1:0] a;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      a = $urandom();
      send_beat(a, 4 + (i % 4), 1'b0);
      checks++;
      if (valid_o !== 1'b1 || out_vec !== a || cnt_o !== FULL) begin
        errors++; $display("FAIL pass[%0d]: valid %b data %h cnt %0d required 1 %h 4", i, valid_o, out_vec, cnt_o, a);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] a, b, d;
    do_reset();
    a = $urandom(); b = $urandom(); d = $urandom();
    send_beat(a, 3, 1'b0);
    send_beat(b, 4, 1'b0);
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: valid %b required 1", valid_o); end
    #2 arst_ni = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || cnt_o !== '0 || out_vec !== '0) begin
      errors++; $display("FAIL mid_async_clear: valid %b cnt %0d data %h required 0 0 0", valid_o, cnt_o, out_vec);
    end
    #2 arst_ni = 1'b1;
    held.delete(); exp_q.delete(); obs_q.delete();
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b required 1", ready_o); end
    tick(); tick();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL mid_no_word: valid %b required 0", valid_o); end
    send_beat(d, 4, 1'b0);
    checks++;
    if (valid_o !== 1'b1 || out_vec !== d || cnt_o !== FULL) begin
      errors++; $display("FAIL mid_fresh: valid %b data %h cnt %0d required 1 %h 4", valid_o, out_vec, cnt_o, d);
    end
  endtask

  task automatic test_random();
    word_t o, x;
    int idx;
    do_reset();
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      send_beat($urandom(), $urandom_range(0, 7), ($urandom_range(0, 3) == 0));
    end
    rand_ready = 1'b0;
    ready_i    = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count: words %0d required %0d", obs_q.size(), exp_q.size());
    end
    idx = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      x = exp_q.pop_front();
      checks++;
      if (o.d !== x.d || o.cnt != x.cnt) begin
        errors++; $display("FAIL rand_word[%0d]: data %h cnt %0d required %h %0d", idx, o.d, o.cnt, x.d, x.cnt);
      end
      idx++;
    end
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_last_drain();
    test_backpressure();
    test_empty_last();
    test_passthrough();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
